// File: rtl/aux_seg_scanner_if.sv
// Display-side bundle for aux_seg_scanner: per-digit content and controls in,
// registered cathode/anode pin drives and the frame strobe out.
interface aux_seg_scanner_if #(
   parameter int DIGITS   = 8,
   parameter int PWM_BITS = 4
);
   logic [4*DIGITS-1:0] data_i;
   logic [DIGITS-1:0]   dp_i;
   logic [DIGITS-1:0]   blank_i;
   logic [DIGITS-1:0]   blink_i;
   logic                lz_en_i;
   logic [PWM_BITS-1:0] bright_i;
   logic [7:0]          seg_n_o;
   logic [DIGITS-1:0]   an_n_o;
   logic                frame_o;

   modport master (
      output data_i, dp_i, blank_i, blink_i, lz_en_i, bright_i,
      input  seg_n_o, an_n_o, frame_o
   );

   modport slave (
      input  data_i, dp_i, blank_i, blink_i, lz_en_i, bright_i,
      output seg_n_o, an_n_o, frame_o
   );
endinterface

// File: rtl/aux_seg_scanner.sv
// Multiplexed 7-segment scan driver: per-digit dp/blank/blink, leading-zero
// suppression, PWM brightness, anti-ghost guard and frame-coherent shadows.
module aux_seg_scanner #(
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int GUARD        = 4,
   parameter int PWM_BITS     = 4,
   parameter int BLINK_FRAMES = 256
) (
   input logic              clk,
   input logic              rst_n,
   aux_seg_scanner_if.slave bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(SCAN_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(DIGITS - 1);
   localparam logic [BF_W-1:0]  BF_MAX    = BF_W'(BLINK_FRAMES - 1);

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
      endcase
   endfunction

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PWM_BITS-1:0] pc_q, pc_d;
   logic [BF_W-1:0]     fcnt_q, fcnt_d;
   logic                phase_q, phase_d;
   logic                pend_q;

   logic [3:0]          nib_q [DIGITS];
   logic [DIGITS-1:0]   dp_s_q, blank_s_q, blink_s_q;
   logic                lz_s_q;
   logic [PWM_BITS-1:0] bright_s_q;

   logic [7:0]          seg_n_q, seg_n_d;
   logic [DIGITS-1:0]   an_n_q, an_n_d;
   logic                frame_q, frame_d;

   logic                wrap_slot, wrap_frame, load;
   logic [DIGITS-1:0]   lzs;
   logic                zero_run, vis, on, drive;

   assign wrap_slot  = (pre_q == PRE_MAX);
   assign wrap_frame = wrap_slot && (idx_q == IDX_MAX);
   assign load       = wrap_frame || pend_q;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and infers a latch.
      pre_d    = pre_q + 1'b1;
      idx_d    = idx_q;
      pc_d     = pc_q + 1'b1;
      fcnt_d   = fcnt_q;
      phase_d  = phase_q;
      frame_d  = wrap_frame;
      lzs      = '0;
      zero_run = lz_s_q;

      if (wrap_slot) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      if (wrap_frame) begin
         if (fcnt_q == BF_MAX) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end

      // A digit is a leading zero only if it and every digit above it are zero.
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (nib_q[i] == 4'h0);
         lzs[i]   = zero_run & (i != 0);
      end

      vis   = ~blank_s_q[idx_q] & ~(blink_s_q[idx_q] & phase_q) & ~lzs[idx_q];
      on    = (bright_s_q == '1) | (pc_q < bright_s_q);
      drive = vis & on & (pre_q >= PRE_GUARD);

      seg_n_d = 8'hFF;
      an_n_d  = '1;
      if (drive) begin
         seg_n_d        = {~dp_s_q[idx_q], glyph(nib_q[idx_q])};
         an_n_d[idx_q]  = 1'b0;
      end
   end

   // NOTE: state is updated only with <=, so every always_comb reader sees the pre-edge value of each _q.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_q      <= '0;
         idx_q      <= '0;
         pc_q       <= '0;
         fcnt_q     <= '0;
         phase_q    <= 1'b0;
         pend_q     <= 1'b1;
         // NOTE: the shadow array is cleared on reset so the first slot never decodes undefined data.
         for (int k = 0; k < DIGITS; k++) nib_q[k] <= '0;
         dp_s_q     <= '0;
         blank_s_q  <= '0;
         blink_s_q  <= '0;
         lz_s_q     <= 1'b0;
         bright_s_q <= '0;
         seg_n_q    <= 8'hFF;
         an_n_q     <= '1;
         frame_q    <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         pc_q    <= pc_d;
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
         pend_q  <= 1'b0;
         if (load) begin
            for (int k = 0; k < DIGITS; k++) nib_q[k] <= bus.data_i[4*k +: 4];
            dp_s_q     <= bus.dp_i;
            blank_s_q  <= bus.blank_i;
            blink_s_q  <= bus.blink_i;
            lz_s_q     <= bus.lz_en_i;
            bright_s_q <= bus.bright_i;
         end
         seg_n_q <= seg_n_d;
         an_n_q  <= an_n_d;
         frame_q <= frame_d;
      end
   end

   assign bus.seg_n_o = seg_n_q;
   assign bus.an_n_o  = an_n_q;
   assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_aux_seg_scanner.sv
// Directed bench for aux_seg_scanner (4 digits, 8-cycle slots, guard 2, 2-bit PWM,
// blink every 2 frames); each cycle's pins are compared to hand-derived values.
module tb_aux_seg_scanner;
   localparam int DIGITS       = 4;
   localparam int SCAN_DIV     = 8;
   localparam int GUARD        = 2;
   localparam int PWM_BITS     = 2;
   localparam int BLINK_FRAMES = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   st    = -1;   // scan state reflected by the outputs currently visible

   aux_seg_scanner_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) bus ();

   aux_seg_scanner #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD),
      .PWM_BITS(PWM_BITS), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s st=%0d: got %h want %h", tag, st, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      st++;
   endtask

   task automatic reset_check(input string tag);
      check({tag, ".an"},    {4'h0, bus.an_n_o}, 8'h0F);
      check({tag, ".seg"},   bus.seg_n_o,        8'hFF);
      check({tag, ".frame"}, {7'h0, bus.frame_o}, 8'h00);
   endtask

   // segs = {d3,d2,d1,d0} cathode bytes; lit = digits visible; duty = bright value
   task automatic check_span(input string tag, input int n, input logic [31:0] segs,
                             input logic [3:0] lit, input int duty);
      for (int c = 0; c < n; c++) begin
         int         pre, idx, pcv;
         logic       lit_e;
         logic [3:0] an_e;
         logic [7:0] seg_e;
         tick();
         pre   = st % 8;
         idx   = (st / 8) % 4;
         pcv   = st % 4;
         lit_e = lit[idx] && (pre >= 2) && (duty == 3 || pcv < duty);
         an_e  = 4'hF;
         seg_e = 8'hFF;
         if (lit_e) begin
            an_e[idx] = 1'b0;
            seg_e     = segs[8*idx +: 8];
         end
         check({tag, ".an"},    {4'h0, bus.an_n_o},  {4'h0, an_e});
         check({tag, ".seg"},   bus.seg_n_o,         seg_e);
         check({tag, ".frame"}, {7'h0, bus.frame_o}, {7'h0, (st % 32 == 31)});
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.data_i   = 16'h1234;
      bus.dp_i     = 4'b0000;
      bus.blank_i  = 4'b0000;
      bus.blink_i  = 4'b0000;
      bus.lz_en_i  = 1'b0;
      bus.bright_i = 2'd3;
      repeat (3) @(posedge clk);
      #1;
      reset_check("rst");
      rst_n = 1'b1;
      st    = -1;

      // T1: full brightness, digits 0..3 show 4,3,2,1
      check_span("t1", 32, 32'hF9A4B099, 4'hF, 3);

      // T5: change content in slot 2; old snapshot holds for the rest of the frame
      check_span("t5a", 20, 32'hF9A4B099, 4'hF, 3);
      bus.data_i   = 16'hABCD;
      bus.bright_i = 2'd1;
      check_span("t5b", 12, 32'hF9A4B099, 4'hF, 3);

      // T2: bright=1 lights only pc==0 cycles, then bright=0 is dark all frame
      bus.bright_i = 2'd0;
      check_span("t2a", 32, 32'h8883C6A1, 4'hF, 1);
      bus.data_i   = 16'h0050;
      bus.lz_en_i  = 1'b1;
      bus.bright_i = 2'd3;
      check_span("t2b", 32, 32'h8883C6A1, 4'hF, 0);

      // T3: leading-zero suppression, then all-zero keeps digit 0
      bus.data_i = 16'h0000;
      check_span("t3a", 32, 32'hFFFF92C0, 4'b0011, 3);
      check_span("t3b", 21, 32'hFFFFFFC0, 4'b0001, 3);

      // T6: reset while the scan sits in slot 2, pre=5
      rst_n        = 1'b0;
      bus.data_i   = 16'h1234;
      bus.lz_en_i  = 1'b0;
      bus.dp_i     = 4'b0010;
      bus.blink_i  = 4'b0001;
      @(posedge clk);
      #1;
      reset_check("t6rst");
      rst_n = 1'b1;
      st    = -1;

      // T4: digit 0 blinks (lit frames 0-1, dark 2-3, lit 4-5); digit 1 dp on
      check_span("t4on",  64, 32'hF9A43099, 4'hF,    3);
      check_span("t4off", 64, 32'hF9A43099, 4'b1110, 3);
      check_span("t4on2", 64, 32'hF9A43099, 4'hF,    3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
